// File: rtl/sar_adc_ctrl_if.sv
// Handshake and analog-control bundle for the SAR ADC controller.
// The master side is the requester and comparator; the slave side is the controller.
interface sar_adc_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             abort;
    logic             cmp_in;
    logic             sample;
    logic             bias_en;
    logic [WIDTH-1:0] dac_code;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, abort, cmp_in,
        input  sample, bias_en, dac_code, busy, done, result
    );

    modport slave (
        input  start, abort, cmp_in,
        output sample, bias_en, dac_code, busy, done, result
    );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: track phase, then one settle/decide slot per bit,
// MSB first, with a synchronized comparator input and registered analog control outputs.
module sar_adc_ctrl #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SAMPLE_CYCLES = 4,
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic               wb_clk_i,
    input  logic               rst_n,
    sar_adc_ctrl_if.slave      bus
);
    localparam int unsigned CntMax = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES
                                                                      : SETTLE_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned BitW   = $clog2(WIDTH);

    localparam logic [CntW-1:0]  SampleLoad = CntW'(SAMPLE_CYCLES - 1);
    localparam logic [CntW-1:0]  SettleLoad = CntW'(SETTLE_CYCLES - 1);
    localparam logic [BitW-1:0]  IdxMsb     = BitW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MsbCode    = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StSample, StSettle, StDecide, StDone} state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [BitW-1:0]  idx_q;
    logic             sample_q;
    logic             bias_en_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] dac_q;
    logic [WIDTH-1:0] result_q;
    logic [1:0]       rst_sync_q;
    logic [1:0]       cmp_sync_q;

    logic run;
    logic cmp_s;
    logic abort_act;

    // Release is delayed two clocks so the FSM never leaves IDLE on a metastable reset edge.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
            cmp_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
            cmp_sync_q <= {cmp_sync_q[0], bus.cmp_in};
        end
    end

    assign run       = rst_sync_q[1];
    assign cmp_s     = cmp_sync_q[1];
    assign abort_act = bus.abort &&
                       ((state_q == StSample) || (state_q == StSettle) || (state_q == StDecide));

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            sample_q  <= 1'b0;
            bias_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dac_q     <= '0;
            result_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort_act) begin
                state_q   <= StIdle;
                sample_q  <= 1'b0;
                bias_en_q <= 1'b0;
                busy_q    <= 1'b0;
                dac_q     <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (run && bus.start && !bus.abort) begin
                            state_q   <= StSample;
                            cnt_q     <= SampleLoad;
                            busy_q    <= 1'b1;
                            bias_en_q <= 1'b1;
                            sample_q  <= 1'b1;
                            dac_q     <= '0;
                        end
                    end
                    StSample: begin
                        if (cnt_q == '0) begin
                            state_q  <= StSettle;
                            cnt_q    <= SettleLoad;
                            sample_q <= 1'b0;
                            dac_q    <= MsbCode;
                            idx_q    <= IdxMsb;
                        end else begin
                            cnt_q <= cnt_q - CntW'(1);
                        end
                    end
                    StSettle: begin
                        if (cnt_q == '0) begin
                            state_q <= StDecide;
                        end else begin
                            cnt_q <= cnt_q - CntW'(1);
                        end
                    end
                    StDecide: begin
                        // Trial bit keeps the comparator verdict; the next lower bit becomes the trial.
                        dac_q[idx_q] <= cmp_s;
                        if (idx_q != '0) begin
                            dac_q[idx_q - BitW'(1)] <= 1'b1;
                            idx_q                   <= idx_q - BitW'(1);
                            cnt_q                   <= SettleLoad;
                            state_q                 <= StSettle;
                        end else begin
                            state_q   <= StDone;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            bias_en_q <= 1'b0;
                            result_q  <= {dac_q[WIDTH-1:1], cmp_s};
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.sample   = sample_q;
    assign bus.bias_en  = bias_en_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.dac_code = dac_q;
    assign bus.result   = result_q;
endmodule
